// File: rtl/pmc_pkg.sv
// -----------------------------------------------------------------------------
// pmc_pkg -- shared definitions for the PMC snapshot reader.
//   PMC_CNT_W   : width of one performance counter (bits)
//   PMC_NUM_CNT : number of counters in a snapshot
//   PMC_SNAP_W  : total snapshot width
//   pmc_state_e : reader FSM states
//   pmc_cnt_e   : counter order inside the snapshot / stream
// -----------------------------------------------------------------------------
package pmc_pkg;

  localparam int PMC_CNT_W   = 256;
  localparam int PMC_NUM_CNT = 4;
  localparam int PMC_SNAP_W  = PMC_CNT_W * PMC_NUM_CNT;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } pmc_state_e;

  // Stream order; also the slot index of each counter inside the snapshot.
  typedef enum logic [1:0] {
    CNT_STALL = 2'd0,
    CNT_CPI   = 2'd1,
    CNT_ARITH = 2'd2,
    CNT_MEM   = 2'd3
  } pmc_cnt_e;

endpackage

// File: rtl/pmc_word_mux.sv
// -----------------------------------------------------------------------------
// pmc_word_mux -- selects one WORD_W-bit word of the snapshot by stream index.
// Word i is snapshot bits [i*WORD_W +: WORD_W], so counters come out in
// pmc_cnt_e order, least-significant word first.
// Optional feature macro: PMC_READER_CHECKSUM_EN -- index N_DATA returns the
// XOR of all data words.
// Ports:
//   i_snap  : captured snapshot (PMC_SNAP_W bits)
//   i_idx   : word index
//   o_word  : selected word (0 for an out-of-range index)
// -----------------------------------------------------------------------------
module pmc_word_mux
  import pmc_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [PMC_SNAP_W-1:0] i_snap,
  input  logic [5:0]            i_idx,
  output logic [WORD_W-1:0]     o_word
);

  localparam int N_DATA = PMC_SNAP_W / WORD_W;

  logic [WORD_W-1:0] w_words [N_DATA];

  for (genvar g = 0; g < N_DATA; g++) begin : g_words
    assign w_words[g] = i_snap[g*WORD_W +: WORD_W];
  end

`ifdef PMC_READER_CHECKSUM_EN
  logic [WORD_W-1:0] w_csum;

  always_comb begin
    w_csum = '0;
    for (int i = 0; i < N_DATA; i++) begin
      w_csum = w_csum ^ w_words[i];
    end
  end
`endif

  // NOTE: o_word gets a default before the loop so every path assigns it and
  // no latch is inferred for index values that match no word.
  always_comb begin
    o_word = '0;
    for (int i = 0; i < N_DATA; i++) begin
      if (i_idx == 6'(i)) o_word = w_words[i];
    end
`ifdef PMC_READER_CHECKSUM_EN
    if (i_idx == 6'(N_DATA)) o_word = w_csum;
`endif
  end

endmodule

// File: rtl/pmc_reader.sv
// -----------------------------------------------------------------------------
// pmc_reader -- captures four 256-bit PMC counters on snap_req and streams them
// out as WORD_W-bit words over a valid/ready handshake.
// Optional feature macro: PMC_READER_CHECKSUM_EN -- appends one XOR checksum
// word after the data words; rd_last moves to that word.
// Ports:
//   clk, reset             : clock, asynchronous active-low reset
//   snap_req               : one-cycle request to capture and stream
//   stall_count_in, cpi_q78_in, arith_count_in, mem_access_count_in : counters
//   rd_data/rd_valid/rd_ready/rd_last/rd_idx : word stream
//   busy                   : snapshot being streamed
//   overrun/clear_overrun  : sticky dropped-request flag and its clear
// -----------------------------------------------------------------------------
module pmc_reader
  import pmc_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 snap_req,
  input  logic [PMC_CNT_W-1:0] stall_count_in,
  input  logic [PMC_CNT_W-1:0] cpi_q78_in,
  input  logic [PMC_CNT_W-1:0] arith_count_in,
  input  logic [PMC_CNT_W-1:0] mem_access_count_in,
  output logic [WORD_W-1:0]    rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 rd_last,
  output logic [5:0]           rd_idx,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 clear_overrun
);

  localparam int N_DATA = PMC_SNAP_W / WORD_W;
`ifdef PMC_READER_CHECKSUM_EN
  localparam int N_WORDS = N_DATA + 1;
`else
  localparam int N_WORDS = N_DATA;
`endif
  localparam logic [5:0] LAST_IDX = 6'(N_WORDS - 1);

  pmc_state_e            r_state, w_state_nxt;
  logic [5:0]            r_idx, w_idx_nxt;
  logic [PMC_SNAP_W-1:0] r_snap, w_snap_in;
  logic                  r_overrun;
  logic                  w_hs, w_final_hs, w_capture, w_overrun_set;
  logic [WORD_W-1:0]     w_word;

  assign w_hs       = (r_state == ST_STREAM) && rd_ready;
  assign w_final_hs = w_hs && (r_idx == LAST_IDX);

  // Counters placed by their stream-order slot.
  always_comb begin
    w_snap_in = '0;
    w_snap_in[int'(CNT_STALL)*PMC_CNT_W +: PMC_CNT_W] = stall_count_in;
    w_snap_in[int'(CNT_CPI)  *PMC_CNT_W +: PMC_CNT_W] = cpi_q78_in;
    w_snap_in[int'(CNT_ARITH)*PMC_CNT_W +: PMC_CNT_W] = arith_count_in;
    w_snap_in[int'(CNT_MEM)  *PMC_CNT_W +: PMC_CNT_W] = mem_access_count_in;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_capture     = 1'b0;
    w_overrun_set = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (snap_req) begin
          w_state_nxt = ST_STREAM;
          w_idx_nxt   = '0;
          w_capture   = 1'b1;
        end
      end
      ST_STREAM: begin
        if (w_final_hs) begin
          // A request on the final handshake chains straight into a new
          // snapshot with no idle cycle.
          w_idx_nxt = '0;
          if (snap_req) w_capture   = 1'b1;
          else          w_state_nxt = ST_IDLE;
        end else begin
          if (w_hs)     w_idx_nxt     = r_idx + 6'd1;
          if (snap_req) w_overrun_set = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // NOTE: the snapshot is reset as well, so a freshly reset reader never
  // exposes stale counter data; it only loads on an accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap <= '0;
    end else if (w_capture) begin
      r_snap <= w_snap_in;
    end
  end

  // Set wins over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_overrun <= 1'b1;
    end else if (clear_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  pmc_word_mux #(
    .WORD_W (WORD_W)
  ) u_word_mux (
    .i_snap (r_snap),
    .i_idx  (r_idx),
    .o_word (w_word)
  );

  assign rd_valid = (r_state == ST_STREAM);
  assign busy     = rd_valid;
  assign rd_idx   = r_idx;
  assign rd_last  = rd_valid && (r_idx == LAST_IDX);
  assign rd_data  = rd_valid ? w_word : '0;
  assign overrun  = r_overrun;

endmodule
